// File: rtl/rfile_pkg.sv
// rfile_pkg: shared types and defaults for the multi-port register file.
package rfile_pkg;

   localparam int ADDR_W_DEF = 5;
   localparam int DATA_W_DEF = 32;

   // Clear sequencer states: CLEAR zeroes the array, RUN is normal operation.
   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } rfile_state_t;

   // Number of entries addressed by an address of the given width.
   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

endpackage

// File: rtl/rfile_clear_fsm.sv
// rfile_clear_fsm: post-reset clear sequencer. Walks every entry once,
// writing zero, then raises ready and freezes its index.
module rfile_clear_fsm
   import rfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              CLK,
   input  logic              RSTN,
   output logic              ready,
   output logic              clr_we,
   output logic [ADDR_W-1:0] clr_addr
);

   localparam int DEPTH = depth_of(ADDR_W);
   // One spare bit so the index can reach DEPTH without wrapping to zero.
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

   rfile_state_t      state, state_nxt;
   logic [ADDR_W:0]   idx, idx_nxt;

   // State and index registers; reset restarts the whole clear sequence.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state <= CLEAR;
         idx   <= '0;
      end else begin
         // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
         state <= state_nxt;
         idx   <= idx_nxt;
      end
   end

   // Next-state and output decode.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a latch behind.
      state_nxt = state;
      idx_nxt   = idx;
      clr_we    = 1'b0;
      ready     = 1'b0;
      case (state)
         CLEAR: begin
            clr_we  = 1'b1;
            idx_nxt = idx + 1'b1;
            if (idx == LAST_IDX) state_nxt = RUN;
         end
         RUN: begin
            ready = 1'b1;
         end
      endcase
   end

   assign clr_addr = idx[ADDR_W-1:0];

endmodule

// File: rtl/rfile_mp.sv
// rfile_mp: parametrised register file with NUM_RD asynchronous read ports,
// NUM_WR synchronous write ports and register 0 hardwired to zero.
// Optional macro RFILE_BYPASS_EN forwards same-cycle write data to reads.
module rfile_mp
   import rfile_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int NUM_RD = 2,
   parameter int NUM_WR = 2
) (
   input  logic                     CLK,
   input  logic                     RSTN,
   input  logic [NUM_WR-1:0]        WE,
   input  logic [NUM_WR*ADDR_W-1:0] A_WR,
   input  logic [NUM_WR*DATA_W-1:0] WD,
   input  logic [NUM_RD*ADDR_W-1:0] A_RD,
   output logic [NUM_RD*DATA_W-1:0] RD,
   output logic                     READY
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic                ready;
   logic                clr_we;
   logic [ADDR_W-1:0]   clr_addr;
   logic [NUM_WR-1:0]   wr_raw;
   logic [NUM_WR-1:0]   wr_en;
   logic [DATA_W-1:0]   mem [DEPTH];

   rfile_clear_fsm #(.ADDR_W(ADDR_W)) u_clear (
      .CLK      (CLK),
      .RSTN     (RSTN),
      .ready    (ready),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
   );

   assign READY = ready;

   // Write-port qualification: running, enabled, and not aimed at register 0.
   always_comb begin
      wr_raw = '0;
      for (int p = 0; p < NUM_WR; p++) begin
         wr_raw[p] = ready && WE[p] && (A_WR[p*ADDR_W +: ADDR_W] != '0);
      end
   end

   // Priority mux: a port is masked when any higher port writes the same address.
   always_comb begin
      wr_en = wr_raw;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            if (wr_raw[q] && (A_WR[q*ADDR_W +: ADDR_W] == A_WR[p*ADDR_W +: ADDR_W]))
               wr_en[p] = 1'b0;
         end
      end
   end

   // Array update: the clear sequencer owns the array until READY is high.
   // NOTE: the storage array has no reset; it is zeroed by the clear sequencer instead.
   always_ff @(posedge CLK) begin
      if (clr_we) begin
         mem[clr_addr] <= '0;
      end else begin
         for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) mem[A_WR[p*ADDR_W +: ADDR_W]] <= WD[p*DATA_W +: DATA_W];
         end
      end
   end

   // Read muxes: zero during clear and for register 0, optional write-through.
   always_comb begin
      RD = '0;
      for (int r = 0; r < NUM_RD; r++) begin
         if (ready && (A_RD[r*ADDR_W +: ADDR_W] != '0)) begin
            RD[r*DATA_W +: DATA_W] = mem[A_RD[r*ADDR_W +: ADDR_W]];
`ifdef RFILE_BYPASS_EN
            for (int p = 0; p < NUM_WR; p++) begin
               if (wr_raw[p] && (A_WR[p*ADDR_W +: ADDR_W] == A_RD[r*ADDR_W +: ADDR_W]))
                  RD[r*DATA_W +: DATA_W] = WD[p*DATA_W +: DATA_W];
            end
`else
`endif
         end
      end
   end

endmodule

// File: tb/tb_rfile_mp.sv
// tb_rfile_mp: self-checking bench for rfile_mp at default parameters.
module tb_rfile_mp;
   import rfile_pkg::*;

   localparam int AW    = 5;
   localparam int DW    = 32;
   localparam int NR    = 2;
   localparam int NW    = 2;
   localparam int DEPTH = 32;

   logic             CLK = 1'b0;
   logic             RSTN = 1'b0;
   logic [NW-1:0]    WE;
   logic [NW*AW-1:0] A_WR;
   logic [NW*DW-1:0] WD;
   logic [NR*AW-1:0] A_RD;
   logic [NR*DW-1:0] RD;
   logic             READY;

   int n_cmp = 0;
   int n_err = 0;

   logic [DW-1:0] ref_mem [DEPTH];
   bit            model_run = 1'b0;

   typedef struct {
      logic [1:0]    we;
      logic [AW-1:0] aw0, aw1;
      logic [DW-1:0] wd0, wd1;
      logic [AW-1:0] ar0, ar1;
      logic [DW-1:0] exp0, exp1;
   } vec_t;

   vec_t vecs [7];

   rfile_mp #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW)) dut (
      .CLK   (CLK),
      .RSTN  (RSTN),
      .WE    (WE),
      .A_WR  (A_WR),
      .WD    (WD),
      .A_RD  (A_RD),
      .RD    (RD),
      .READY (READY)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_wr(input int p, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
      WE[p]          = we;
      A_WR[p*AW +: AW] = a;
      WD[p*DW +: DW]   = d;
   endtask

   task automatic set_rd(input int r, input logic [AW-1:0] a);
      A_RD[r*AW +: AW] = a;
   endtask

   function automatic logic [DW-1:0] rd_of(input int r);
      return RD[r*DW +: DW];
   endfunction

   function automatic logic [AW-1:0] rand_addr();
      if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 3));
      return AW'($urandom_range(0, DEPTH - 1));
   endfunction

   // Expected read value from the architectural view of the register file.
   function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      if (!model_run || a == 0) return '0;
      v = ref_mem[a];
`ifdef RFILE_BYPASS_EN
      for (int p = 0; p < NW; p++)
         if (WE[p] && A_WR[p*AW +: AW] == a) v = WD[p*DW +: DW];
`endif
      return v;
   endfunction

   // One rising edge; the model commits writes in port order so the highest port wins.
   task automatic tick();
      @(posedge CLK);
      if (model_run) begin
         for (int p = 0; p < NW; p++)
            if (WE[p] && A_WR[p*AW +: AW] != 0) ref_mem[A_WR[p*AW +: AW]] = WD[p*DW +: DW];
      end
      #1;
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
   endtask

   initial begin
      vecs[0] = '{2'b01, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
      vecs[1] = '{2'b11, 5'd0, 5'd0, 32'h12345678, 32'h12345678, 5'd0, 5'd0, 32'h0, 32'h0};
      vecs[2] = '{2'b11, 5'd9, 5'd9, 32'h00001111, 32'h00002222, 5'd9, 5'd9, 32'h00002222, 32'h00002222};
      vecs[3] = '{2'b10, 5'd0, 5'd31, 32'h0, 32'hCAFEF00D, 5'd31, 5'd5, 32'hCAFEF00D, 32'hDEADBEEF};
      vecs[4] = '{2'b00, 5'd5, 5'd9, 32'h0BADBAD0, 32'h0BADBAD0, 5'd5, 5'd9, 32'hDEADBEEF, 32'h00002222};
      vecs[5] = '{2'b11, 5'd1, 5'd2, 32'h00000001, 32'hFFFFFFFF, 5'd1, 5'd2, 32'h00000001, 32'hFFFFFFFF};
      vecs[6] = '{2'b11, 5'd0, 5'd9, 32'h77777777, 32'h33333333, 5'd0, 5'd9, 32'h0, 32'h33333333};

      WE = '0; A_WR = '0; WD = '0; A_RD = '0;
      clear_model();

      // Reset state.
      repeat (3) @(posedge CLK);
      #1;
      check("reset_ready", 32'(READY), 32'd0);
      set_rd(0, 5); set_rd(1, 31);
      #1;
      check("reset_rd0", rd_of(0), '0);
      check("reset_rd1", rd_of(1), '0);

      // Clear sequence, with a write attempt to address 3 on edge 10.
      RSTN = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         if (k == 10) begin set_wr(0, 1, 3, 32'hAAAA); set_wr(1, 1, 3, 32'hAAAA); end
         if (k == 11) WE = '0;
         tick();
         check($sformatf("clear_ready_%0d", k), 32'(READY), (k == DEPTH) ? 32'd1 : 32'd0);
         if (k < DEPTH) begin
            set_rd(0, AW'($urandom_range(1, DEPTH - 1)));
            #1;
            check("clear_rd0", rd_of(0), '0);
         end
      end
      model_run = 1'b1;
      clear_model();
      set_rd(0, 3); set_rd(1, 3);
      #1;
      check("clear_wr_ignored", rd_of(0), '0);

      // Table-driven write/read vectors.
      for (int v = 0; v < 7; v++) begin
         set_wr(0, vecs[v].we[0], vecs[v].aw0, vecs[v].wd0);
         set_wr(1, vecs[v].we[1], vecs[v].aw1, vecs[v].wd1);
         tick();
         WE = '0;
         set_rd(0, vecs[v].ar0); set_rd(1, vecs[v].ar1);
         #1;
         check($sformatf("vec%0d_rd0", v), rd_of(0), vecs[v].exp0);
         check($sformatf("vec%0d_rd1", v), rd_of(1), vecs[v].exp1);
      end

      // Same-cycle write and read of one address.
      set_wr(0, 1, 7, 32'h5); set_wr(1, 0, 0, 0);
      tick();
      set_wr(0, 1, 7, 32'h9); set_rd(0, 7);
      #1;
`ifdef RFILE_BYPASS_EN
      check("bypass_before_edge", rd_of(0), 32'h9);
`else
      check("readfirst_before_edge", rd_of(0), 32'h5);
`endif
      tick();
      WE = '0;
      #1;
      check("wr_after_edge", rd_of(0), 32'h9);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NW; p++) set_wr(p, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
         for (int r = 0; r < NR; r++) set_rd(r, rand_addr());
         #1;
         for (int r = 0; r < NR; r++)
            check($sformatf("rand%0d_rd%0d", c, r), rd_of(r), model_rd(A_RD[r*AW +: AW]));
         tick();
      end
      WE = '0;

      // Fill every entry with non-zero data, then reset mid-run.
      for (int a = 1; a < DEPTH; a++) begin
         set_wr(0, 1, AW'(a), $urandom | 32'h1);
         tick();
      end
      WE = '0;
      set_rd(0, 17); set_rd(1, 31);
      #1;
      check("fill_rd0", rd_of(0), model_rd(17));
      #1;
      RSTN = 1'b0;
      #1;
      model_run = 1'b0;
      check("midrun_reset_ready", 32'(READY), 32'd0);
      check("midrun_reset_rd1", rd_of(1), '0);
      @(posedge CLK);
      #1;
      RSTN = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         tick();
         if (k >= DEPTH - 1)
            check($sformatf("reclear_ready_%0d", k), 32'(READY), (k == DEPTH) ? 32'd1 : 32'd0);
      end
      model_run = 1'b1;
      clear_model();
      for (int a = 0; a < DEPTH; a += 2) begin
         set_rd(0, AW'(a)); set_rd(1, AW'(a + 1));
         #1;
         check($sformatf("reclear_rd_%0d", a), rd_of(0), '0);
         check($sformatf("reclear_rd_%0d", a + 1), rd_of(1), '0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
